rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-004 SHALL: req0_addr  input  5  requester 0 destination register.
REQ-005 SHALL: req0_data  input  32  requester 0 write data.
REQ-006 SHALL: req0_ready  output  1  requester 0 write accepted this cycle.
REQ-007 SHALL: req1_valid / req1_addr / req1_data / req1_ready  same widths and meaning as REQ-003..006, for requester 1 (load / mul-div writeback).
REQ-008 SHALL: rf_stall  input  1  register-file write port unavailable this cycle.
REQ-009 SHALL: rf_we  output  1  write enable to the 32x32 register file.
REQ-010 SHALL: rf_waddr  output  5  register-file write address.
REQ-011 SHALL: rf_wdata  output  32  register-file write data.
REQ-012 SHALL: busy  output  1  output stage holds an unissued write.
REQ-013 SHALL: drop_cnt  output  8  count of accepted writes to register 0.
REQ-014 SHALL: fwd_raddr1, fwd_raddr2  input  5 each  read addresses to check against the in-flight write.
REQ-015 SHALL: fwd_hit1, fwd_hit2  output  1 each; fwd_data1, fwd_data2  output  32 each  forwarding results.

Function
REQ-016 SHALL: internal output stage = out_valid, out_addr[4:0], out_data[31:0]; busy = out_valid.
REQ-017 SHALL: rf_we = out_valid & ~rf_stall; rf_waddr = out_addr; rf_wdata = out_data (combinational from the stage).
REQ-018 SHALL: can_accept = ~out_valid | ~rf_stall; no request is granted when can_accept = 0.
REQ-019 SHALL: at most one grant per cycle; reqN_ready = 1 only for the granted requester; ready may depend on valid.
REQ-020 SHALL: round-robin arbitration; a 1-bit priority pointer selects the preferred requester; the non-preferred requester is granted only when the preferred one is not valid.
REQ-021 SHALL: after a grant to requester N, pointer = the other requester; with no grant the pointer holds.
REQ-022 SHALL: a requester holds valid/addr/data stable until it sees ready; the arbiter does not check this.
REQ-023 SHALL: a grant with addr != 0 loads the stage (out_valid = 1) at the next edge; latency accept -> rf_we = 1 cycle when rf_stall = 0.
REQ-024 SHALL: a grant with addr == 0 is accepted (ready = 1) but not loaded; drop_cnt increments, saturating at 255.
REQ-025 SHALL: when the stage issues (rf_we = 1) with no new grant, or a zero-address grant, out_valid clears at the next edge.
REQ-026 SHALL: issue and new grant in the same cycle reload the stage; sustained throughput = 1 write/cycle.
REQ-027 SHALL: while rf_stall = 1 and out_valid = 1, the stage holds its contents and both readies = 0.
REQ-028 SHALL: writes reach the register file in acceptance order; back-to-back writes to the same address issue in order.

Reset
REQ-029 SHALL: rst_n = 0 asynchronously clears out_valid, out_addr, out_data, pointer (requester 0 preferred) and drop_cnt.
REQ-030 SHALL: during reset rf_we = 0, req0_ready = req1_ready = 0, busy = 0, fwd_hit1 = fwd_hit2 = 0, fwd_data1 = fwd_data2 = 0.
REQ-031 SHALL: reset mid-operation discards any unissued stage write; it is never issued after reset release.

Configuration
REQ-032 SHALL: with macro RF_ARB_FWD_EN defined, fwd_hitK = out_valid & (out_addr == fwd_raddrK) & (out_addr != 0), and fwd_dataK = out_data when fwd_hitK = 1, else 0.
REQ-033 SHALL: without RF_ARB_FWD_EN, fwd_hit1/2 and fwd_data1/2 are constant 0; all other behaviour is unchanged.

Verification
REQ-034 SHALL: req0 valid, addr 5, data 0xDEADBEEF, rf_stall = 0 -> req0_ready = 1 that cycle; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF.
REQ-035 SHALL: both requesters valid for 4 cycles from reset -> grants 0,1,0,1; rf_we = 1 on 4 consecutive cycles.
REQ-036 SHALL: stage loaded, rf_stall = 1 for 3 cycles -> rf_we = 0, readies 0, busy = 1; on the cycle stall drops, rf_we = 1 with the held data.
REQ-037 SHALL: 300 accepted writes to addr 0 -> rf_we never asserts; drop_cnt = 255.
REQ-038 SHALL: RF_ARB_FWD_EN defined, stage holds addr 7 data 0x12345678, fwd_raddr1 = 7, fwd_raddr2 = 8 -> fwd_hit1 = 1, fwd_data1 = 0x12345678, fwd_hit2 = 0, fwd_data2 = 0.
REQ-039 SHALL: rst_n asserted while stage valid with rf_stall = 1 -> rf_we = 0 immediately; after release, no write is issued until a new grant.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Two-requester round-robin write arbiter for a 32x32 register file, with a one-entry output stage.
// Optional write-to-read forwarding is compiled in when RF_ARB_FWD_EN is defined.
module rf_wr_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        rf_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  input  logic [4:0]  fwd_raddr1,
  input  logic [4:0]  fwd_raddr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  logic        r_out_valid;
  logic [4:0]  r_out_addr;
  logic [31:0] r_out_data;
  logic        r_ptr;
  logic [7:0]  r_drop_cnt;

  logic        w_can_accept;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_grant;
  logic [4:0]  w_gaddr;
  logic [31:0] w_gdata;
  logic        w_issue;

  // Readies are gated by rst_n so nothing is granted while reset is held.
  assign w_can_accept = rst_n & (~r_out_valid | ~rf_stall);
  assign w_grant0     = w_can_accept & req0_valid & (~r_ptr | ~req1_valid);
  assign w_grant1     = w_can_accept & req1_valid & ( r_ptr | ~req0_valid);
  assign w_grant      = w_grant0 | w_grant1;
  assign w_gaddr      = w_grant1 ? req1_addr : req0_addr;
  assign w_gdata      = w_grant1 ? req1_data : req0_data;
  assign w_issue      = r_out_valid & ~rf_stall;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rf_we      = w_issue;
  assign rf_waddr   = r_out_addr;
  assign rf_wdata   = r_out_data;
  assign busy       = r_out_valid;
  assign drop_cnt   = r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_ptr       <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_grant) begin
        r_ptr <= w_grant0;
        if (w_gaddr != 5'd0) begin
          r_out_valid <= 1'b1;
          r_out_addr  <= w_gaddr;
          r_out_data  <= w_gdata;
        end else begin
          // x0 writes are acknowledged but never reach the file.
          r_out_valid <= 1'b0;
          if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end else if (w_issue) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef RF_ARB_FWD_EN
  logic w_hit1;
  logic w_hit2;

  assign w_hit1    = r_out_valid & (r_out_addr == fwd_raddr1) & (r_out_addr != 5'd0);
  assign w_hit2    = r_out_valid & (r_out_addr == fwd_raddr2) & (r_out_addr != 5'd0);
  assign fwd_hit1  = w_hit1;
  assign fwd_hit2  = w_hit2;
  assign fwd_data1 = w_hit1 ? r_out_data : 32'd0;
  assign fwd_data2 = w_hit2 ? r_out_data : 32'd0;
`else
  logic [9:0] w_fwd_unused;

  assign w_fwd_unused = {fwd_raddr1, fwd_raddr2};
  assign fwd_hit1     = 1'b0;
  assign fwd_hit2     = 1'b0;
  assign fwd_data1    = 32'd0;
  assign fwd_data2    = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter; forwarding expectations follow RF_ARB_FWD_EN.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .drop_cnt(drop_cnt),
    .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic        exp_hit1;
  logic [31:0] exp_fd1;
  int          bad;

  initial begin
    rst_n = 1'b0; rf_stall = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h2222_2222;
    fwd_raddr1 = 5'd0; fwd_raddr2 = 5'd0;

    // Reset state with requests present.
    @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_fwd", {fwd_hit1, fwd_hit2, fwd_data1 | fwd_data2}, 0);
    next_cycle();
    rst_n = 1'b1;
    req1_valid = 1'b0;
    req0_data = 32'hDEAD_BEEF;

    // Single write, one-cycle latency.
    @(negedge clk);
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    chk("single_we_pre", rf_we, 0);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 5);
    chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("single_busy", busy, 1);
    next_cycle();
    @(negedge clk);
    chk("single_idle_we", rf_we, 0);
    chk("single_idle_busy", busy, 0);

    // Round robin from reset: grants 0,1,0,1, writes every cycle.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA0A0_0010;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hB1B1_0011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ready0_%0d", k), req0_ready, (k % 2 == 0));
      chk($sformatf("rr_ready1_%0d", k), req1_ready, (k % 2 == 1));
      if (k > 0) begin
        chk($sformatf("rr_we_%0d", k), rf_we, 1);
        chk($sformatf("rr_waddr_%0d", k), rf_waddr, (k % 2 == 1) ? 10 : 11);
      end
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rr_we_4", rf_we, 1);
    chk("rr_waddr_4", rf_waddr, 11);
    chk("rr_wdata_4", rf_wdata, 32'hB1B1_0011);
    next_cycle();

    // Stall holds the stage; release issues held data, then acceptance order.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hCAFE_0003;
    @(negedge clk);
    chk("stall_load_ready0", req0_ready, 1);
    next_cycle();
    rf_stall = 1'b1;
    req0_addr = 5'd4; req0_data = 32'hCAFE_0004;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hCAFE_0006;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_we_%0d", k), rf_we, 0);
      chk($sformatf("stall_readies_%0d", k), {req0_ready, req1_ready}, 0);
      chk($sformatf("stall_busy_%0d", k), busy, 1);
      chk($sformatf("stall_wdata_%0d", k), rf_wdata, 32'hCAFE_0003);
      next_cycle();
    end
    rf_stall = 1'b0;
    @(negedge clk);
    chk("unstall_we", rf_we, 1);
    chk("unstall_waddr", rf_waddr, 3);
    chk("unstall_wdata", rf_wdata, 32'hCAFE_0003);
    chk("unstall_ready1", req1_ready, 1);
    chk("unstall_ready0", req0_ready, 0);
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("order_waddr_a", rf_waddr, 6);
    chk("order_we_a", rf_we, 1);
    chk("order_ready0", req0_ready, 1);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("order_waddr_b", rf_waddr, 4);
    chk("order_wdata_b", rf_wdata, 32'hCAFE_0004);
    next_cycle();

    // Forwarding from a held stage.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1234_5678;
    fwd_raddr1 = 5'd7; fwd_raddr2 = 5'd8;
    @(negedge clk);
    chk("fwd_load_ready0", req0_ready, 1);
    next_cycle();
    req0_valid = 1'b0;
    rf_stall = 1'b1;
`ifdef RF_ARB_FWD_EN
    exp_hit1 = 1'b1; exp_fd1 = 32'h1234_5678;
`else
    exp_hit1 = 1'b0; exp_fd1 = 32'h0;
`endif
    @(negedge clk);
    chk("fwd_busy", busy, 1);
    chk("fwd_hit1", fwd_hit1, exp_hit1);
    chk("fwd_data1", fwd_data1, exp_fd1);
    chk("fwd_hit2", fwd_hit2, 0);
    chk("fwd_data2", fwd_data2, 0);

    // Reset while a stalled write is pending discards it.
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", rf_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_hit1", fwd_hit1, 0);
    next_cycle();
    rst_n = 1'b1;
    rf_stall = 1'b0;
    @(negedge clk);
    chk("postrst_we_a", rf_we, 0);
    next_cycle();
    @(negedge clk);
    chk("postrst_we_b", rf_we, 0);
    chk("postrst_busy", busy, 0);
    next_cycle();

    // Writes to x0 are accepted, never issued, and counted with saturation.
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req0_ready !== 1'b1 || rf_we !== 1'b0 || busy !== 1'b0) bad++;
      next_cycle();
      if (i == 9) chk("drop_cnt_10", drop_cnt, 10);
    end
    req0_valid = 1'b0;
    chk("drop_bad_cycles", bad, 0);
    chk("drop_cnt_sat", drop_cnt, 255);
    @(negedge clk);
    chk("drop_final_we", rf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
